// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Purpose  : Round-robin arbiter that shares a 4-to-1 mux between four
//            requesters. Ownership is registered so the mux select is stable
//            for the whole ownership period; handover between owners happens
//            on a single edge with no idle cycle.
// Ports    : clk       in   clock, rising edge
//            rst_n     in   asynchronous active-low reset
//            req       in   [NUM_REQ-1:0]   request vector
//            gnt       out  [NUM_REQ-1:0]   one-hot grant, zero when idle
//            sel       out  [SEL_WIDTH-1:0] mux select (holds while idle)
//            sel_valid out  high when gnt is non-zero
// Options  : `define MUX_ARB_TIMEOUT_EN to build the hold counter that forces
//            rotation after MAX_HOLD consecutive grant cycles when another
//            requester is waiting.
// Revision : 1.0  initial release
// ============================================================================
module mux_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SEL_WIDTH = 2,
    parameter int MAX_HOLD  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 sel_valid
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [SEL_WIDTH-1:0] r_ptr;
    logic [SEL_WIDTH-1:0] w_ptr_nxt;
    logic [SEL_WIDTH-1:0] r_sel;
    logic [SEL_WIDTH-1:0] w_sel_nxt;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;

    logic                 w_release;
    logic [SEL_WIDTH-1:0] w_search_ptr;
    logic [NUM_REQ-1:0]   w_search_mask;
    logic [SEL_WIDTH-1:0] w_idx;
    logic                 w_found;
    logic [SEL_WIDTH-1:0] w_win;
    logic [NUM_REQ-1:0]   w_win_onehot;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int                 HOLD_W   = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0]  HOLD_SAT = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;

    // Forced release only when someone else is actually waiting; otherwise
    // the owner keeps the mux and the counter stays saturated.
    assign w_release = !req[r_sel] ||
                       ((r_hold == HOLD_SAT) && (|(req & ~r_gnt)));
`else
    assign w_release = !req[r_sel];
`endif

    // ------------------------------------------------------------------
    // Priority search. While granting, the search starts just past the
    // current owner and the owner is masked out, which makes the old owner
    // lowest priority both for voluntary and for forced release.
    // ------------------------------------------------------------------
    always_comb begin
        if (r_state == ST_GRANT) begin
            w_search_ptr  = r_sel + SEL_WIDTH'(1);
            w_search_mask = req & ~r_gnt;
        end else begin
            w_search_ptr  = r_ptr;
            w_search_mask = req;
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Index arithmetic wraps naturally because NUM_REQ == 2**SEL_WIDTH.
            w_idx = w_search_ptr + SEL_WIDTH'(i);
            if (!w_found && w_search_mask[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            r_hold  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
            r_valid <= w_valid_nxt;
`ifdef MUX_ARB_TIMEOUT_EN
            r_hold  <= w_hold_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
        w_valid_nxt = r_valid;
`ifdef MUX_ARB_TIMEOUT_EN
        w_hold_nxt  = r_hold;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_win;
                    w_gnt_nxt   = w_win_onehot;
                    w_valid_nxt = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
                    w_hold_nxt  = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_ptr_nxt = w_search_ptr;
                    if (w_found) begin
                        // Direct handover: new owner on the same edge.
                        w_sel_nxt   = w_win;
                        w_gnt_nxt   = w_win_onehot;
                        w_valid_nxt = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
                        w_hold_nxt  = '0;
`endif
                    end else begin
                        // sel keeps its value so the mux output stays stable.
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                        w_valid_nxt = 1'b0;
                    end
                end else begin
`ifdef MUX_ARB_TIMEOUT_EN
                    if (r_hold != HOLD_SAT) begin
                        w_hold_nxt = r_hold + HOLD_W'(1);
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs come straight from registers.
    // ------------------------------------------------------------------
    always_comb begin
        gnt       = r_gnt;
        sel       = r_sel;
        sel_valid = r_valid;
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_arbiter
// Purpose  : Directed self-checking bench for mux_rr_arbiter plus a bounded
//            random run checking grant invariants and wait bounds.
//            Expectations for the timeout scenario follow MUX_ARB_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_rr_arbiter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       sel_valid;

    int n_checks = 0;
    int n_pass   = 0;

    mux_rr_arbiter u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .sel_valid (sel_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic v);
        check({tag, ".gnt"}, 32'(gnt), 32'(g));
        check({tag, ".sel"}, 32'(sel), 32'(s));
        check({tag, ".valid"}, 32'(sel_valid), 32'(v));
    endtask

    // Drive req at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Fairness vectors: each owner keeps req for 2 granted cycles, then drops it.
    logic [3:0] fair_req [9] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                                 4'b1111, 4'b1011, 4'b1111, 4'b0111};
    logic [3:0] fair_gnt [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    logic [1:0] fair_sel [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

    initial begin
        logic [3:0]  prev_gnt;
        logic [31:0] rv;
        logic        start;
        int          wait_cnt [4];
        int          exp_sel;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- single requester ----------------
        for (int k = 0; k < 5; k++) begin
            step(4'b0100);
            expect_out("single_hold", 4'b0100, 2'd2, 1'b1);
        end
        for (int k = 0; k < 2; k++) begin
            step(4'b0000);
            expect_out("single_idle", 4'b0000, 2'd2, 1'b0);
        end

        // ---------------- round-robin fairness ----------------
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(fair_req[k]);
            expect_out("fair", fair_gnt[k], fair_sel[k], 1'b1);
        end

        // ---------------- wrap-around ----------------
        step(4'b0000);                         // owner 0 releases, ptr -> 1
        expect_out("wrap_idle", 4'b0000, 2'd0, 1'b0);
        step(4'b1000);                         // search 1,2,3 -> 3
        expect_out("wrap_own3", 4'b1000, 2'd3, 1'b1);
        step(4'b0011);                         // owner 3 releases, ptr -> 0
        expect_out("wrap_to0", 4'b0001, 2'd0, 1'b1);

        // ---------------- asynchronous reset mid-grant ----------------
        step(4'b0010);
        expect_out("pre_rst_a", 4'b0010, 2'd1, 1'b1);
        step(4'b1111);
        expect_out("pre_rst_b", 4'b0010, 2'd1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        step(4'b1111);
        expect_out("post_rst", 4'b0001, 2'd0, 1'b1);

        // ---------------- timeout behaviour ----------------
        do_reset();
        for (int k = 0; k < 24; k++) begin
            step(4'b0011);
`ifdef MUX_ARB_TIMEOUT_EN
            exp_sel = (k / 8) % 2;
`else
            exp_sel = 0;
`endif
            expect_out("timeout", (exp_sel == 0) ? 4'b0001 : 4'b0010, 2'(exp_sel), 1'b1);
        end

        // ---------------- random stress ----------------
        do_reset();
        prev_gnt = 4'b0000;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        for (int k = 0; k < 1000; k++) begin
            rv = $urandom;
            step(req ^ (rv[3:0] & rv[7:4]));
            check("onehot", 32'($countones(gnt) <= 1), 32'd1);
            check("gnt_sel", 32'(gnt[sel]), 32'(sel_valid));
            check("valid", 32'(sel_valid), 32'(gnt != 4'b0000));
            start = (gnt != 4'b0000) && (gnt != prev_gnt);
            for (int i = 0; i < 4; i++) begin
                if (!req[i] || gnt[i]) begin
                    wait_cnt[i] = 0;
                end else if (start) begin
                    wait_cnt[i] = wait_cnt[i] + 1;
                end
                check("wait_bound", 32'(wait_cnt[i] <= 3), 32'd1);
            end
            prev_gnt = gnt;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
